name_streamer: RTL
==================

NAME_STREAMER -- requirements
Module: name_streamer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, width of one name component.
REQ-002 SHALL have parameter MAX_NAME_LENGTH, default 8, maximum name length in components.
REQ-003 SHALL have parameter LEN_W, default 4, width of name length fields; SHALL hold MAX_NAME_LENGTH.
REQ-004 clk_in  input  1  sole clock; all logic on rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset.
REQ-006 name_valid_in  input  1  upstream offers a full name.
REQ-007 name_ready_out  output  1  streamer accepts a name this cycle.
REQ-008 name_words_in  input  MAX_NAME_LENGTH*WORD_SIZE  flattened name; component k occupies slot MAX_NAME_LENGTH-1-k.
REQ-009 name_len_in  input  LEN_W  number of valid components.
REQ-010 stall_in  input  1  lookup pipeline holds; streamer freezes.
REQ-011 name_component_out  output  WORD_SIZE  component driven into lookup pipeline.
REQ-012 component_valid_out  output  1  name_component_out is a real beat.
REQ-013 component_index_out  output  LEN_W  index k of current beat.
REQ-014 last_out  output  1  final beat of current name.
REQ-015 busy_out  output  1  a name is loaded and not yet fully emitted.

Function
REQ-016 SHALL implement FSM states IDLE, STREAM, PAD; PAD reachable only with NAME_STREAMER_PAD_EN.
REQ-017 Handshake: name accepted on rising edge with name_valid_in=1 and name_ready_out=1; words and length captured into internal buffer.
REQ-018 name_ready_out SHALL be 1 in IDLE, and in STREAM/PAD only during the final beat with stall_in=0.
REQ-019 Latency: first beat on the cycle after acceptance; one beat per unstalled cycle, no gaps.
REQ-020 Beat order: k = 0,1,...,len-1; beat k drives slot MAX_NAME_LENGTH-1-k.
REQ-021 name_len_in > MAX_NAME_LENGTH SHALL be clamped to MAX_NAME_LENGTH.
REQ-022 name_len_in = 0 without pad: accepted, no beats emitted, stays IDLE.
REQ-023 stall_in=1: all outputs, index counter and state hold; name_ready_out forced 0.
REQ-024 Back-to-back: acceptance during final beat makes next name's k=0 beat follow on the next cycle.
REQ-025 last_out SHALL be 1 only together with component_valid_out=1 on the final beat.
REQ-026 Outside valid beats: name_component_out=0, component_index_out=0, last_out=0.
REQ-027 Index counter SHALL NOT wrap; it returns to 0 only on a new acceptance or reset.

Reset
REQ-028 rst_in=1 SHALL force IDLE, all outputs 0 except name_ready_out=0 during reset and 1 on first cycle after.
REQ-029 Reset mid-name SHALL discard buffered name; no further beats of it.

Configuration
REQ-030 NAME_STREAMER_PAD_EN defined: after len real beats, zero-word beats with component_valid_out=1 continue until MAX_NAME_LENGTH beats total; last_out on beat MAX_NAME_LENGTH-1; len 0 yields MAX_NAME_LENGTH zero beats.
REQ-031 NAME_STREAMER_PAD_EN undefined: exactly len beats per name, no PAD state logic.

Structure
REQ-032 Shared package ndn_fib_pkg SHALL hold WORD_SIZE, MAX_NAME_LENGTH, LEN_W defaults and the FSM state enum.
REQ-033 SHALL be a single module; no sub-module.

Verification
REQ-034 Reset then name len 3, words 0xA0,0xA1,0xA2 at k=0..2 -> beats 0xA0,0xA1,0xA2 on cycles 1-3 after accept, last_out on 0xA2.
REQ-035 Two names len 2 back-to-back (0x11,0x12 then 0x21,0x22) -> four consecutive beats, no bubble.
REQ-036 Len 8, stall_in=1 for 3 cycles at k=4 -> beat k=4 held 4 cycles, total 11 cycles.
REQ-037 Len 12 -> clamped, 8 beats, last_out at k=7.
REQ-038 rst_in asserted at k=2 of len-6 name -> outputs 0 next cycle, name_ready_out=1 after release, no residual beats.
REQ-039 With NAME_STREAMER_PAD_EN, len 2 (0x5,0x6) -> 0x5,0x6 then six 0x0 beats, last_out at k=7; len 0 -> eight 0x0 beats.

Source files
------------

// File: rtl/ndn_fib_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ndn_fib_pkg
// Description : Shared defaults and FSM state encoding for the name streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package ndn_fib_pkg;

    localparam int c_WORD_SIZE       = 32;
    localparam int c_MAX_NAME_LENGTH = 8;
    localparam int c_LEN_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2
    } stream_state_t;

endpackage
`default_nettype wire

// File: rtl/name_streamer.sv
`default_nettype none
// ============================================================================
// Module      : name_streamer
// Description : Accepts a whole name (up to MAX_NAME_LENGTH components) and
//               emits it one component per unstalled cycle into the lookup
//               pipeline. Optional macro NAME_STREAMER_PAD_EN pads every name
//               with zero beats up to MAX_NAME_LENGTH beats.
// Revision    : 1.0 - initial release
// ============================================================================
module name_streamer
    import ndn_fib_pkg::*;
#(
    parameter int WORD_SIZE       = c_WORD_SIZE,
    parameter int MAX_NAME_LENGTH = c_MAX_NAME_LENGTH,
    parameter int LEN_W           = c_LEN_W
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 name_valid_in,
    output logic                                 name_ready_out,
    input  logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_words_in,
    input  logic [LEN_W-1:0]                     name_len_in,
    input  logic                                 stall_in,
    output logic [WORD_SIZE-1:0]                 name_component_out,
    output logic                                 component_valid_out,
    output logic [LEN_W-1:0]                     component_index_out,
    output logic                                 last_out,
    output logic                                 busy_out
);

    localparam logic [LEN_W-1:0] c_MAX_LEN  = LEN_W'(MAX_NAME_LENGTH);
    localparam logic [LEN_W-1:0] c_LAST_IDX = LEN_W'(MAX_NAME_LENGTH - 1);

    stream_state_t        r_state;
    stream_state_t        w_state_nxt;
    logic [LEN_W-1:0]     r_index;
    logic [LEN_W-1:0]     w_index_nxt;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     w_len_clamped;
    logic [WORD_SIZE-1:0] r_buf [MAX_NAME_LENGTH];
    logic [WORD_SIZE-1:0] w_word;
    logic                 w_load;
    logic                 w_stream_end;
    logic                 w_final;

    // Oversized lengths are treated as a full-length name
    always_comb begin
        w_len_clamped = (name_len_in > c_MAX_LEN) ? c_MAX_LEN : name_len_in;
    end

    // Decode whether the beat currently presented is the last one of the name
    always_comb begin
        w_stream_end = (r_index == (r_len - LEN_W'(1)));
        w_final      = 1'b0;
        case (r_state)
`ifdef NAME_STREAMER_PAD_EN
            ST_STREAM: w_final = w_stream_end && (r_len == c_MAX_LEN);
            ST_PAD:    w_final = (r_index == c_LAST_IDX);
`else
            ST_STREAM: w_final = w_stream_end;
`endif
            default:   w_final = 1'b0;
        endcase
    end

    // State, beat index and name buffer registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_len   <= '0;
            for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            if (w_load) begin
                r_len <= w_len_clamped;
                // component k lives in slot MAX_NAME_LENGTH-1-k of the flat bus
                for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
                    r_buf[k] <= name_words_in[(MAX_NAME_LENGTH-1-k)*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    // Next-state logic; a stall freezes everything, acceptance overrides the rest
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_load      = 1'b0;
        if (!stall_in) begin
            case (r_state)
                ST_STREAM: begin
                    if (!w_stream_end) begin
                        w_index_nxt = r_index + LEN_W'(1);
                    end else begin
`ifdef NAME_STREAMER_PAD_EN
                        if (r_len != c_MAX_LEN) begin
                            w_state_nxt = ST_PAD;
                            w_index_nxt = r_index + LEN_W'(1);
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
`else
                        w_state_nxt = ST_IDLE;
`endif
                    end
                end
`ifdef NAME_STREAMER_PAD_EN
                ST_PAD: begin
                    if (r_index != c_LAST_IDX) begin
                        w_index_nxt = r_index + LEN_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
`endif
                default: w_state_nxt = ST_IDLE;
            endcase

            if (name_valid_in && name_ready_out) begin
                w_load      = 1'b1;
                w_index_nxt = '0;
                if (w_len_clamped != '0) begin
                    w_state_nxt = ST_STREAM;
                end else begin
`ifdef NAME_STREAMER_PAD_EN
                    w_state_nxt = ST_PAD;
`else
                    w_state_nxt = ST_IDLE;
`endif
                end
            end
        end
    end

    // Select the buffered component addressed by the beat index
    always_comb begin
        w_word = '0;
        for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
            if (r_index == LEN_W'(k)) begin
                w_word = r_buf[k];
            end
        end
    end

    // Output decode; everything reads zero outside a valid beat
    always_comb begin
        name_ready_out      = !rst_in && !stall_in && ((r_state == ST_IDLE) || w_final);
        component_valid_out = 1'b0;
        name_component_out  = '0;
        component_index_out = '0;
        last_out            = 1'b0;
        busy_out            = 1'b0;
        case (r_state)
            ST_STREAM: begin
                component_valid_out = 1'b1;
                name_component_out  = w_word;
                component_index_out = r_index;
                last_out            = w_final;
                busy_out            = 1'b1;
            end
`ifdef NAME_STREAMER_PAD_EN
            ST_PAD: begin
                component_valid_out = 1'b1;
                component_index_out = r_index;
                last_out            = w_final;
                busy_out            = 1'b1;
            end
`endif
            default: begin
                component_valid_out = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
